sprite_plotter: RTL and testbench

Pixel-write engine directly downstream of the sprite movement FSM. It takes the character position, colour and one-cycle `drawChar`/`drawBG` requests, and scans a fixed-size sprite box into single-pixel VGA adapter writes (`plot`, x, y, colour). It clips pixels that fall off screen and returns one-cycle `doneChar`/`doneBG` pulses that advance the movement FSM out of its wait states.

---
 rtl/sprite_pkg.sv | 22 ++
 rtl/pixel_scan_counter.sv | 52 +++++
 rtl/sprite_plotter.sv | 123 ++++++++++++
 tb/tb_sprite_plotter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants and encodings for the sprite pixel plotter.
// Holds screen bounds, colour constants and the plotter state/mode types.
package sprite_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_RED   = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } plot_state_e;

    typedef enum logic {
        MODE_CHAR = 1'b0,
        MODE_BG   = 1'b1
    } plot_mode_e;

endpackage

// File: rtl/pixel_scan_counter.sv
// Raster column/row counter walking a SPRITE_W x SPRITE_H box.
// Ports: clock, resetn, start (clear), step (advance) -> i, j, last.
module pixel_scan_counter #(
    parameter int SPRITE_W = 4,
    parameter int SPRITE_H = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic       step,
    output logic [2:0] i,
    output logic [2:0] j,
    output logic       last
);

    localparam logic [2:0] I_MAX = 3'(SPRITE_W - 1);
    localparam logic [2:0] J_MAX = 3'(SPRITE_H - 1);

    logic [2:0] i_q, i_d;
    logic [2:0] j_q, j_d;

    always_comb begin
        i_d = i_q;
        j_d = j_q;
        if (start) begin
            i_d = '0;
            j_d = '0;
        end else if (step) begin
            if (i_q == I_MAX) begin
                i_d = '0;
                j_d = (j_q == J_MAX) ? 3'd0 : j_q + 3'd1;
            end else begin
                i_d = i_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            i_q <= '0;
            j_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
        end
    end

    assign i    = i_q;
    assign j    = j_q;
    assign last = (i_q == I_MAX) && (j_q == J_MAX);

endmodule

// File: rtl/sprite_plotter.sv
// Scans a sprite box into single-pixel VGA writes with clipping and masking.
// Ports: clock/resetn, position/colour/requests in; vga_*, plot, busy, done out.
module sprite_plotter
    import sprite_pkg::*;
#(
    parameter int                         SPRITE_W    = 4,
    parameter int                         SPRITE_H    = 4,
    parameter logic [SPRITE_W*SPRITE_H-1:0] SPRITE_MASK = 16'hFFFF,
    parameter logic [2:0]                 BG_COLOUR   = COL_BLACK
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] xCoordinate,
    input  logic [6:0] yCoordinate,
    input  logic [2:0] color,
    input  logic       drawChar,
    input  logic       drawBG,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       doneChar,
    output logic       doneBG
);

    // Zero-extended so any 6-bit mask index is in range.
    localparam logic [63:0] MASK_EXT = 64'(SPRITE_MASK);

    plot_state_e state_q, state_d;
    plot_mode_e  mode_q, mode_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [2:0]  col_q, col_d;

    logic       accept;
    logic       in_scan;
    logic [2:0] ci, cj;
    logic       last;
    logic [8:0] px;
    logic [7:0] py;
    logic [5:0] idx;

    assign accept  = (state_q == IDLE) && (drawChar || drawBG);
    assign in_scan = (state_q == SCAN);

    pixel_scan_counter #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H)
    ) u_cnt (
        .clock  (clock),
        .resetn (resetn),
        .start  (accept),
        .step   (in_scan),
        .i      (ci),
        .j      (cj),
        .last   (last)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        x_d     = x_q;
        y_d     = y_q;
        col_d   = col_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SCAN;
                    x_d     = xCoordinate;
                    y_d     = yCoordinate;
                    // Erase takes priority; a simultaneous draw is dropped.
                    mode_d  = drawBG ? MODE_BG : MODE_CHAR;
                    col_d   = drawBG ? BG_COLOUR : color;
                end
            end
            SCAN: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            mode_q  <= MODE_CHAR;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
        end
    end

    // Extra carry bit lets the clip test catch wrap past the screen edge.
    assign px  = {1'b0, x_q} + {6'b0, ci};
    assign py  = {1'b0, y_q} + {5'b0, cj};
    assign idx = {3'b0, cj} * 6'(SPRITE_W) + {3'b0, ci};

    assign vga_x      = px[7:0];
    assign vga_y      = py[6:0];
    assign vga_colour = col_q;

    assign plot = in_scan
                && (px < 9'(SCREEN_W))
                && (py < 8'(SCREEN_H))
                && ((mode_q == MODE_BG) || MASK_EXT[idx]);

    assign busy     = (state_q != IDLE);
    assign doneChar = (state_q == DONE) && (mode_q == MODE_CHAR);
    assign doneBG   = (state_q == DONE) && (mode_q == MODE_BG);

endmodule

// File: tb/tb_sprite_plotter.sv
// Self-checking bench for sprite_plotter: full-mask and single-pixel-mask
// instances share stimulus and are compared against a per-cycle model.
module tb_sprite_plotter;

    logic       clock;
    logic       resetn;
    logic [7:0] xCoordinate;
    logic [6:0] yCoordinate;
    logic [2:0] color;
    logic       drawChar;
    logic       drawBG;

    logic [7:0] vx0, vx1;
    logic [6:0] vy0, vy1;
    logic [2:0] vc0, vc1;
    logic       pl0, pl1, bz0, bz1, dc0, dc1, db0, db1;

    int n_cmp = 0;
    int n_err = 0;

    // expected per cycle after the request edge: {plot,busy,doneChar,doneBG}
    // and {x,y,colour} (only meaningful when plot is expected)
    logic [3:0]  e_ctl [2][1:18];
    logic [17:0] e_pix [2][1:18];
    logic [3:0]  o_ctl [2];
    logic [17:0] o_pix [2];

    assign o_ctl[0] = {pl0, bz0, dc0, db0};
    assign o_ctl[1] = {pl1, bz1, dc1, db1};
    assign o_pix[0] = {vx0, vy0, vc0};
    assign o_pix[1] = {vx1, vy1, vc1};

    sprite_plotter u_dut (
        .clock(clock), .resetn(resetn),
        .xCoordinate(xCoordinate), .yCoordinate(yCoordinate),
        .color(color), .drawChar(drawChar), .drawBG(drawBG),
        .vga_x(vx0), .vga_y(vy0), .vga_colour(vc0),
        .plot(pl0), .busy(bz0), .doneChar(dc0), .doneBG(db0)
    );

    sprite_plotter #(.SPRITE_MASK(16'h0001)) u_msk (
        .clock(clock), .resetn(resetn),
        .xCoordinate(xCoordinate), .yCoordinate(yCoordinate),
        .color(color), .drawChar(drawChar), .drawBG(drawBG),
        .vga_x(vx1), .vga_y(vy1), .vga_colour(vc1),
        .plot(pl1), .busy(bz1), .doneChar(dc1), .doneBG(db1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: raster walk of a 4x4 box, clipped to 160x120, masked in draw mode.
    function automatic void model(input bit bg, input int x, input int y,
                                  input logic [2:0] col);
        logic [15:0] mask;
        for (int m = 0; m < 2; m++) begin
            mask = (m == 0) ? 16'hFFFF : 16'h0001;
            for (int c = 1; c <= 18; c++) begin
                if (c <= 16) begin
                    int i, j, px, py;
                    bit p;
                    i  = (c - 1) % 4;
                    j  = (c - 1) / 4;
                    px = x + i;
                    py = y + j;
                    p  = (px < 160) && (py < 120) && (bg || mask[j*4+i]);
                    e_ctl[m][c] = {p, 1'b1, 2'b00};
                    e_pix[m][c] = {8'(px), 7'(py), bg ? 3'b000 : col};
                end else if (c == 17) begin
                    e_ctl[m][c] = {2'b01, !bg, bg};
                    e_pix[m][c] = '0;
                end else begin
                    e_ctl[m][c] = 4'b0000;
                    e_pix[m][c] = '0;
                end
            end
        end
    endfunction

    task automatic request(input bit ch, input bit bg, input logic [7:0] x,
                           input logic [6:0] y, input logic [2:0] col);
        @(negedge clock);
        xCoordinate = x;
        yCoordinate = y;
        color       = col;
        drawChar    = ch;
        drawBG      = bg;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        drawChar = 0; drawBG = 0;
        xCoordinate = 8'd77; yCoordinate = 7'd33; color = 3'b111;
        repeat (2) @(negedge clock);
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if ({o_ctl[m], o_pix[m]} !== 22'd0) begin
                n_err++;
                $display("FAIL reset_vals inst%0d got %h want 0", m,
                         {o_ctl[m], o_pix[m]});
            end
        end
        resetn = 1'b1;
        repeat (2) @(negedge clock);
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (o_ctl[m] !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_idle inst%0d got %b want 0000", m, o_ctl[m]);
            end
        end
    endtask

    task automatic test_char_draw();
        int np [2];
        np[0] = 0; np[1] = 0;
        model(0, 10, 20, 3'b100);
        request(1, 0, 8'd10, 7'd20, 3'b100);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clock);
            if (c == 1) begin drawChar = 0; color = 3'b011; xCoordinate = 8'd0; end
            for (int m = 0; m < 2; m++) begin
                np[m] += int'(o_ctl[m][3]);
                n_cmp++;
                if (o_ctl[m] !== e_ctl[m][c]) begin
                    n_err++;
                    $display("FAIL char_ctl inst%0d c%0d got %b want %b",
                             m, c, o_ctl[m], e_ctl[m][c]);
                end
                if (e_ctl[m][c][3]) begin
                    n_cmp++;
                    if (o_pix[m] !== e_pix[m][c]) begin
                        n_err++;
                        $display("FAIL char_pix inst%0d c%0d got %h want %h",
                                 m, c, o_pix[m], e_pix[m][c]);
                    end
                end
            end
        end
        n_cmp++;
        if (np[0] != 16 || np[1] != 1) begin
            n_err++;
            $display("FAIL char_count got %0d/%0d want 16/1", np[0], np[1]);
        end
    endtask

    task automatic test_bg_clip();
        int np;
        np = 0;
        model(1, 158, 118, 3'b000);
        request(0, 1, 8'd158, 7'd118, 3'b101);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clock);
            if (c == 1) drawBG = 0;
            np += int'(o_ctl[0][3]);
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (o_ctl[m] !== e_ctl[m][c]) begin
                    n_err++;
                    $display("FAIL bg_ctl inst%0d c%0d got %b want %b",
                             m, c, o_ctl[m], e_ctl[m][c]);
                end
                if (e_ctl[m][c][3]) begin
                    n_cmp++;
                    if (o_pix[m] !== e_pix[m][c]) begin
                        n_err++;
                        $display("FAIL bg_pix inst%0d c%0d got %h want %h",
                                 m, c, o_pix[m], e_pix[m][c]);
                    end
                end
            end
        end
        n_cmp++;
        if (np != 4) begin
            n_err++;
            $display("FAIL bg_count got %0d want 4", np);
        end
    endtask

    task automatic test_both_req();
        int nd;
        nd = 0;
        model(1, 40, 50, 3'b000);
        request(1, 1, 8'd40, 7'd50, 3'b110);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clock);
            if (c == 1) begin drawChar = 0; drawBG = 0; end
            if (c == 6) drawChar = 0;
            nd += int'(o_ctl[0][1]) + int'(o_ctl[0][0]);
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (o_ctl[m] !== e_ctl[m][c]) begin
                    n_err++;
                    $display("FAIL both_ctl inst%0d c%0d got %b want %b",
                             m, c, o_ctl[m], e_ctl[m][c]);
                end
                if (e_ctl[m][c][3]) begin
                    n_cmp++;
                    if (o_pix[m] !== e_pix[m][c]) begin
                        n_err++;
                        $display("FAIL both_pix inst%0d c%0d got %h want %h",
                                 m, c, o_pix[m], e_pix[m][c]);
                    end
                end
            end
            if (c == 5) begin drawChar = 1; xCoordinate = 8'd3; end
        end
        n_cmp++;
        if (nd != 1) begin
            n_err++;
            $display("FAIL both_done_count got %0d want 1", nd);
        end
    endtask

    task automatic test_reset_midscan();
        model(0, 10, 20, 3'b100);
        request(1, 0, 8'd10, 7'd20, 3'b100);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            if (c == 1) drawChar = 0;
            n_cmp++;
            if (o_ctl[0] !== e_ctl[0][c]) begin
                n_err++;
                $display("FAIL midrst_ctl c%0d got %b want %b",
                         c, o_ctl[0], e_ctl[0][c]);
            end
        end
        resetn = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if ({o_ctl[m], o_pix[m]} !== 22'd0) begin
                n_err++;
                $display("FAIL midrst_async inst%0d got %h want 0", m,
                         {o_ctl[m], o_pix[m]});
            end
        end
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clock);
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (o_ctl[m] !== 4'b0000) begin
                    n_err++;
                    $display("FAIL midrst_nodone inst%0d c%0d got %b want 0000",
                             m, c, o_ctl[m]);
                end
            end
        end
        test_char_draw();
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            bit ch, bg;
            int x, y, xr;
            logic [2:0] col;
            int extra;
            xr = $urandom_range(0, 3);
            x  = (xr == 0) ? $urandom_range(150, 255) : $urandom_range(0, 255);
            y  = (xr == 1) ? $urandom_range(110, 127) : $urandom_range(0, 127);
            col = 3'($urandom);
            bg  = ($urandom_range(0, 2) == 0);
            ch  = bg ? ($urandom_range(0, 1) == 1) : 1'b1;
            extra = $urandom_range(2, 16);
            model(bg, x, y, col);
            repeat ($urandom_range(0, 3)) @(negedge clock);
            request(ch, bg, 8'(x), 7'(y), col);
            for (int c = 1; c <= 18; c++) begin
                @(negedge clock);
                drawChar = 0;
                drawBG   = 0;
                if (c == 3) begin
                    xCoordinate = 8'($urandom);
                    yCoordinate = 7'($urandom);
                    color       = 3'($urandom);
                end
                for (int m = 0; m < 2; m++) begin
                    n_cmp++;
                    if (o_ctl[m] !== e_ctl[m][c]) begin
                        n_err++;
                        $display("FAIL rnd_ctl t%0d inst%0d c%0d got %b want %b",
                                 t, m, c, o_ctl[m], e_ctl[m][c]);
                    end
                    if (e_ctl[m][c][3]) begin
                        n_cmp++;
                        if (o_pix[m] !== e_pix[m][c]) begin
                            n_err++;
                            $display("FAIL rnd_pix t%0d inst%0d c%0d got %h want %h",
                                     t, m, c, o_pix[m], e_pix[m][c]);
                        end
                    end
                end
                if (c == extra) begin
                    drawChar = 1'($urandom);
                    drawBG   = 1'($urandom);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_char_draw();
        test_bg_clip();
        test_both_req();
        test_reset_midscan();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
